uart_byte_tx: RTL and testbench

Serial UART transmitter that sits directly downstream of the ADC sample packetiser. It accepts one byte per `txd_en_go` strobe, serialises it onto `uart_tx` as a standard 8N1 frame (8E1 when parity is compiled in), and reports activity on `txd_busy`. The packetiser uses the falling edge of `txd_busy` to advance from low byte to high byte to the next FIFO entry.

---
 rtl/uart_byte_tx.sv | 157 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// One byte per txd_en_go strobe, LSB first; txd_busy/tx_done are registered.
module uart_byte_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txd_data,
    input  logic       txd_en_go,
    output logic       txd_busy,
    output logic       tx_done,
    output logic       uart_tx
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (cyc_q == CYC_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (txd_en_go) begin
                    shift_d = txd_data;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^txd_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line and busy are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign uart_tx  = tx_q;
    assign txd_busy = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: cycle-level frame model plus a mid-bit sampling receiver.
// Honours UART_TX_PARITY_EN (frame length and parity bit follow the same macro).
module tb_uart_byte_tx;

    localparam int BC  = 434;
    localparam int BC4 = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int L = FB * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, go, go4;
    logic [7:0] data, data4;
    logic       busy, done, tx, busy4, done4, tx4;

    uart_byte_tx dut (
        .clk(clk), .rst(rst), .txd_data(data), .txd_en_go(go),
        .txd_busy(busy), .tx_done(done), .uart_tx(tx)
    );

    uart_byte_tx #(.BIT_CYCLES(BC4)) dut4 (
        .clk(clk), .rst(rst), .txd_data(data4), .txd_en_go(go4),
        .txd_busy(busy4), .tx_done(done4), .uart_tx(tx4)
    );

    int errors = 0;
    int checks = 0;

    logic       obs_tx[$], obs_busy[$], obs_done[$];
    logic       exp_tx[$], exp_busy[$], exp_done[$];
    int         ev_at[$];
    logic [7:0] ev_dat[$];
    int         rst_at;
    logic [7:0] acc_bytes[$];
    logic       rx_line[$];
    logic [7:0] rx_bytes[$];
    int         rx_ferr;

    // Bit k of a frame: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic begin_frame(input logic [7:0] b);
        @(negedge clk);
        obs_tx.delete(); obs_busy.delete(); obs_done.delete();
        ev_at.delete(); ev_dat.delete(); acc_bytes.delete();
        ev_at.push_back(-1); ev_dat.push_back(b);
        data = b;
        go   = 1'b1;
    endtask

    // Samples the main DUT each cycle; optionally strobes at s1/s2 and pulses reset at r.
    task automatic capture(input int ncyc, input int s1, input logic [7:0] d1,
                           input int s2, input logic [7:0] d2, input int r);
        rst_at = r;
        if (s1 >= 0) begin ev_at.push_back(s1); ev_dat.push_back(d1); end
        if (s2 >= 0) begin ev_at.push_back(s2); ev_dat.push_back(d2); end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            obs_tx.push_back(tx);
            obs_busy.push_back(busy);
            obs_done.push_back(done);
            go  = 1'b0;
            rst = 1'b0;
            if (i == s1) begin go = 1'b1; data = d1; end
            if (i == s2) begin go = 1'b1; data = d2; end
            if (i == r) rst = 1'b1;
        end
        go  = 1'b0;
        rst = 1'b0;
    endtask

    // Expected trace from the frame rules: a strobe is taken only when no frame
    // occupies that cycle and reset is not asserted; reset truncates and drops tx_done.
    task automatic run_model();
        int n, busy_until, s, e;
        bit trunc;
        n = obs_tx.size();
        exp_tx.delete(); exp_busy.delete(); exp_done.delete();
        for (int c = 0; c < n; c++) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
        end
        busy_until = -1;
        for (int j = 0; j < ev_at.size(); j++) begin
            if (ev_at[j] >= busy_until && ev_at[j] != rst_at) begin
                s = ev_at[j] + 1;
                e = s + L;
                trunc = (rst_at >= s && rst_at <= e - 1);
                if (trunc) e = rst_at + 1;
                for (int c = s; c < e && c < n; c++) begin
                    exp_tx[c]   = frame_bit((c - s) / BC, ev_dat[j]);
                    exp_busy[c] = 1'b1;
                end
                if (!trunc && e < n) exp_done[e] = 1'b1;
                busy_until = e;
                acc_bytes.push_back(ev_dat[j]);
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < obs_tx.size(); i++)
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                return i;
        return 0;
    endfunction

    function automatic int count_ones(input int which);
        int c = 0;
        for (int i = 0; i < obs_tx.size(); i++)
            if ((which == 0) ? obs_busy[i] : obs_done[i]) c++;
        return c;
    endfunction

    // Idle-high receiver: find a falling edge, sample every bit at its centre.
    task automatic rx_decode(input int bc);
        int i, last;
        logic prev;
        logic [7:0] b;
        rx_bytes.delete();
        rx_ferr = 0;
        i = 0;
        prev = 1'b1;
        while (i < rx_line.size()) begin
            if (prev && !rx_line[i]) begin
                last = i + (FB - 1) * bc + bc / 2;
                if (last >= rx_line.size()) break;
                if (rx_line[i + bc / 2] !== 1'b0) rx_ferr++;
                for (int k = 0; k < 8; k++) b[k] = rx_line[i + (k + 1) * bc + bc / 2];
                if (PAR && rx_line[i + 9 * bc + bc / 2] !== ^b) rx_ferr++;
                if (rx_line[last] !== 1'b1) rx_ferr++;
                rx_bytes.push_back(b);
                i = last + 1;
                prev = 1'b1;
            end else begin
                prev = rx_line[i];
                i++;
            end
        end
    endtask

    task automatic load_rx(input int from);
        rx_line.delete();
        for (int i = from; i < obs_tx.size(); i++) rx_line.push_back(obs_tx[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; go4 = 1'b0; data = '0; data4 = '0;
        repeat (3) @(negedge clk);
        checks++; if ({tx, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset_main: {uart_tx,txd_busy,tx_done}=%b expected 100", {tx, busy, done});
        end
        checks++; if ({tx4, busy4, done4} !== 3'b100) begin
            errors++; $display("FAIL reset_bc4: {uart_tx,txd_busy,tx_done}=%b expected 100", {tx4, busy4, done4});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx, busy, done} !== 3'b100) begin
            errors++; $display("FAIL idle_after_reset: {uart_tx,txd_busy,tx_done}=%b expected 100", {tx, busy, done});
        end
    endtask

    task automatic test_frame_55();
        int idx;
        begin_frame(8'h55);
        capture(L + 2, -1, 8'h00, -1, 8'h00, -100);
        run_model();
        idx = first_diff();
        checks++; if ({obs_tx[idx], obs_busy[idx], obs_done[idx]} !== {exp_tx[idx], exp_busy[idx], exp_done[idx]}) begin
            errors++; $display("FAIL f55_trace cycle %0d: {uart_tx,txd_busy,tx_done}=%b expected %b", idx,
                {obs_tx[idx], obs_busy[idx], obs_done[idx]}, {exp_tx[idx], exp_busy[idx], exp_done[idx]});
        end
        checks++; if (count_ones(0) !== L) begin
            errors++; $display("FAIL f55_busy_len: %0d cycles expected %0d", count_ones(0), L);
        end
        checks++; if (count_ones(1) !== 1) begin
            errors++; $display("FAIL f55_done_count: %0d expected 1", count_ones(1));
        end
        load_rx(0); rx_decode(BC);
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 8'h55 || rx_ferr !== 0) begin
            errors++; $display("FAIL f55_rx: %0d bytes first=%h ferr=%0d expected 1 byte 55 ferr=0",
                rx_bytes.size(), (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx, rx_ferr);
        end
    endtask

    task automatic test_latch_ignore();
        int idx;
        begin_frame(8'hA3);
        capture(L + 2, 2000, 8'hFF, L - 1, 8'hFF, -100);
        run_model();
        idx = first_diff();
        checks++; if ({obs_tx[idx], obs_busy[idx], obs_done[idx]} !== {exp_tx[idx], exp_busy[idx], exp_done[idx]}) begin
            errors++; $display("FAIL latch_trace cycle %0d: {uart_tx,txd_busy,tx_done}=%b expected %b", idx,
                {obs_tx[idx], obs_busy[idx], obs_done[idx]}, {exp_tx[idx], exp_busy[idx], exp_done[idx]});
        end
        checks++; if (count_ones(1) !== 1) begin
            errors++; $display("FAIL latch_done_count: %0d expected 1", count_ones(1));
        end
        checks++; if (obs_busy[L + 1] !== 1'b0) begin
            errors++; $display("FAIL stop_strobe_ignored: txd_busy=%b expected 0", obs_busy[L + 1]);
        end
        load_rx(0); rx_decode(BC);
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 8'hA3) begin
            errors++; $display("FAIL latch_rx: %0d bytes first=%h expected 1 byte a3",
                rx_bytes.size(), (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        logic [7:0] b0;
        b0 = 8'($urandom);
        begin_frame(b0);
        capture(2 * L + 3, L, 8'h01, -1, 8'h00, -100);
        run_model();
        idx = first_diff();
        checks++; if ({obs_tx[idx], obs_busy[idx], obs_done[idx]} !== {exp_tx[idx], exp_busy[idx], exp_done[idx]}) begin
            errors++; $display("FAIL b2b_trace cycle %0d: {uart_tx,txd_busy,tx_done}=%b expected %b", idx,
                {obs_tx[idx], obs_busy[idx], obs_done[idx]}, {exp_tx[idx], exp_busy[idx], exp_done[idx]});
        end
        checks++; if ({obs_busy[L], obs_done[L], obs_tx[L + 1], obs_busy[L + 1]} !== 4'b0101) begin
            errors++; $display("FAIL b2b_edge: {busy,done@fall,tx,busy@next}=%b expected 0101",
                {obs_busy[L], obs_done[L], obs_tx[L + 1], obs_busy[L + 1]});
        end
        load_rx(0); rx_decode(BC);
        checks++; if (rx_bytes.size() !== 2 || rx_bytes[0] !== b0 || rx_bytes[1] !== 8'h01) begin
            errors++; $display("FAIL b2b_rx: %0d bytes expected 2 (%h,01)", rx_bytes.size(), b0);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        begin_frame(8'($urandom));
        capture(2006 + L + 2, 2000, 8'hC3, 2005, 8'h3C, 2000);
        run_model();
        idx = first_diff();
        checks++; if ({obs_tx[idx], obs_busy[idx], obs_done[idx]} !== {exp_tx[idx], exp_busy[idx], exp_done[idx]}) begin
            errors++; $display("FAIL rstmid_trace cycle %0d: {uart_tx,txd_busy,tx_done}=%b expected %b", idx,
                {obs_tx[idx], obs_busy[idx], obs_done[idx]}, {exp_tx[idx], exp_busy[idx], exp_done[idx]});
        end
        checks++; if ({obs_tx[2001], obs_busy[2001], obs_done[2001]} !== 3'b100) begin
            errors++; $display("FAIL rstmid_after: {uart_tx,txd_busy,tx_done}=%b expected 100",
                {obs_tx[2001], obs_busy[2001], obs_done[2001]});
        end
        checks++; if (count_ones(1) !== 1) begin
            errors++; $display("FAIL rstmid_done_count: %0d expected 1", count_ones(1));
        end
        load_rx(2001); rx_decode(BC);
        checks++; if (rx_bytes.size() !== 1 || rx_bytes[0] !== 8'h3C) begin
            errors++; $display("FAIL rstmid_rx: %0d bytes first=%h expected 1 byte 3c",
                rx_bytes.size(), (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx);
        end
    endtask

    task automatic test_parity();
        int idx;
        logic [7:0] pb [2];
        pb[0] = 8'h07;
        pb[1] = 8'h03;
        for (int t = 0; t < 2; t++) begin
            begin_frame(pb[t]);
            capture(L + 2, -1, 8'h00, -1, 8'h00, -100);
            run_model();
            idx = first_diff();
            checks++; if ({obs_tx[idx], obs_busy[idx], obs_done[idx]} !== {exp_tx[idx], exp_busy[idx], exp_done[idx]}) begin
                errors++; $display("FAIL par%0d_trace cycle %0d: {uart_tx,txd_busy,tx_done}=%b expected %b", t, idx,
                    {obs_tx[idx], obs_busy[idx], obs_done[idx]}, {exp_tx[idx], exp_busy[idx], exp_done[idx]});
            end
            checks++; if (count_ones(0) !== L) begin
                errors++; $display("FAIL par%0d_busy_len: %0d cycles expected %0d", t, count_ones(0), L);
            end
`ifdef UART_TX_PARITY_EN
            checks++; if (obs_tx[9 * BC + BC / 2] !== ((t == 0) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL par%0d_bit: parity=%b expected %b", t, obs_tx[9 * BC + BC / 2], (t == 0));
            end
`endif
        end
    endtask

    // Packetiser-style driver: next byte is strobed on the txd_busy falling cycle.
    task automatic test_random_bc4();
        logic [7:0] bytes [16];
        int nsent, ndone, cyc;
        logic prev_busy, finished;
        for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
        rx_line.delete();
        nsent = 1; ndone = 0; cyc = 0; prev_busy = 1'b0; finished = 1'b0;
        @(negedge clk);
        data4 = bytes[0];
        go4   = 1'b1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            rx_line.push_back(tx4);
            if (done4) ndone++;
            go4 = 1'b0;
            if (prev_busy && !busy4) begin
                if (nsent < 16) begin
                    data4 = bytes[nsent];
                    go4   = 1'b1;
                    nsent++;
                end else begin
                    finished = 1'b1;
                end
            end
            prev_busy = busy4;
        end
        go4 = 1'b0;
        checks++; if (finished !== 1'b1) begin
            errors++; $display("FAIL bc4_timeout: finished=%b after %0d cycles expected 1", finished, cyc);
        end
        rx_decode(BC4);
        checks++; if (rx_bytes.size() !== 16) begin
            errors++; $display("FAIL bc4_rx_count: %0d expected 16", rx_bytes.size());
        end
        for (int k = 0; k < 16 && k < rx_bytes.size(); k++) begin
            checks++; if (rx_bytes[k] !== bytes[k]) begin
                errors++; $display("FAIL bc4_rx_byte%0d: %h expected %h", k, rx_bytes[k], bytes[k]);
            end
        end
        checks++; if (rx_ferr !== 0) begin
            errors++; $display("FAIL bc4_framing: %0d errors expected 0", rx_ferr);
        end
        checks++; if (ndone !== 16) begin
            errors++; $display("FAIL bc4_done_count: %0d expected 16", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_latch_ignore();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        test_random_bc4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
